// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the 12-bit pixel colour type.
package vga_pkg;

   localparam int unsigned CNT_W    = 10;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FP     = 16;
   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_BP     = 48;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BP     = 33;

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525
   localparam int unsigned HS_START = H_ACTIVE + H_FP;                  // 656
   localparam int unsigned HS_END   = HS_START + H_SYNC - 1;            // 751
   localparam int unsigned VS_START = V_ACTIVE + V_FP;                  // 490
   localparam int unsigned VS_END   = VS_START + V_SYNC - 1;            // 491

   // Bit [11:8] red, [7:4] green, [3:0] blue.
   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

endpackage

// File: rtl/vga_scan_cnt.sv
// Pixel-rate divider and horizontal/vertical scan counters.
module vga_scan_cnt
   import vga_pkg::CNT_W;
#(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned H_TOTAL = 800,
   parameter int unsigned V_TOTAL = 525
) (
   input  logic             i_clk,
   input  logic             i_rst,
   output logic [CNT_W-1:0] o_h_cnt,
   output logic [CNT_W-1:0] o_v_cnt,
   output logic             o_pix_step
);

   localparam logic [2:0]       PH_MAX = 3'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   logic [2:0]       r_ph;
   logic [CNT_W-1:0] r_h_cnt;
   logic [CNT_W-1:0] r_v_cnt;
   logic             w_step;

   assign w_step     = (r_ph == PH_MAX);
   assign o_pix_step = w_step;
   assign o_h_cnt    = r_h_cnt;
   assign o_v_cnt    = r_v_cnt;

   // Phase divider and scan position, advanced once per pixel period.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ph    <= '0;
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else begin
         r_ph <= w_step ? '0 : r_ph + 3'd1;
         if (w_step) begin
            if (r_h_cnt == H_LAST) begin
               r_h_cnt <= '0;
               r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
            end else begin
               r_h_cnt <= r_h_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator: scan position out to render, blanked and
// sync-aligned colour out to the DAC pins, plus a per-frame tick.
module vga_ctrl
   import vga_pkg::CNT_W, vga_pkg::rgb_t;
#(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned RENDER_LAT = 1,
   parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
   parameter int unsigned H_FP       = vga_pkg::H_FP,
   parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
   parameter int unsigned H_BP       = vga_pkg::H_BP,
   parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
   parameter int unsigned V_FP       = vga_pkg::V_FP,
   parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
   parameter int unsigned V_BP       = vga_pkg::V_BP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [11:0]      rgb_in,
   output logic [CNT_W-1:0] col,
   output logic [CNT_W-1:0] row,
   output logic             active,
   output logic             frame_tick,
   output logic             hs,
   output logic             vs,
   output logic [3:0]       r,
   output logic [3:0]       g,
   output logic [3:0]       b
);

   localparam int unsigned L_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned L_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] C_HA     = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] C_VA     = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] C_HS_LO  = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] C_HS_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] C_VS_LO  = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] C_VS_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(L_H_TOTAL - 1);
   localparam logic [CNT_W-1:0] C_VA_M1  = CNT_W'(V_ACTIVE - 1);

   if (CLK_DIV < 2 || CLK_DIV > 8) begin : g_div_err
      $error("vga_ctrl: CLK_DIV must be in 2..8");
   end
   if (RENDER_LAT > CLK_DIV - 1) begin : g_lat_err
      $error("vga_ctrl: RENDER_LAT must be <= CLK_DIV-1");
   end

   logic [CNT_W-1:0] w_h_cnt;
   logic [CNT_W-1:0] w_v_cnt;
   logic             w_step;
   logic             w_active;
   logic             w_hs_on;
   logic             w_vs_on;
   rgb_t             w_rgb;

   logic             r_hs;
   logic             r_vs;
   rgb_t             r_rgb;
   logic             r_frame_tick;

   vga_scan_cnt #(
      .CLK_DIV (CLK_DIV),
      .H_TOTAL (L_H_TOTAL),
      .V_TOTAL (L_V_TOTAL)
   ) u_scan (
      .i_clk      (clk),
      .i_rst      (rst),
      .o_h_cnt    (w_h_cnt),
      .o_v_cnt    (w_v_cnt),
      .o_pix_step (w_step)
   );

   assign w_active = (w_h_cnt < C_HA) && (w_v_cnt < C_VA);
   assign w_hs_on  = (w_h_cnt >= C_HS_LO) && (w_h_cnt <= C_HS_HI);
   assign w_vs_on  = (w_v_cnt >= C_VS_LO) && (w_v_cnt <= C_VS_HI);
   assign w_rgb    = rgb_t'(rgb_in);

   assign col        = w_h_cnt;
   assign row        = w_v_cnt;
   assign active     = w_active;
   assign frame_tick = r_frame_tick;
   assign hs         = r_hs;
   assign vs         = r_vs;
   assign r          = r_rgb.r;
   assign g          = r_rgb.g;
   assign b          = r_rgb.b;

   // Pin registers: colour and syncs for the same pixel captured on one step;
   // the tick marks the step that lands on the first vertical-blank line.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hs         <= 1'b1;
         r_vs         <= 1'b1;
         r_rgb        <= '0;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= w_step && (w_h_cnt == C_H_LAST) && (w_v_cnt == C_VA_M1);
         if (w_step) begin
            r_hs  <= ~w_hs_on;
            r_vs  <= ~w_vs_on;
            r_rgb <= w_active ? w_rgb : '0;
         end
      end
   end

endmodule
